uart_txrx: RTL

Parametrised, synthesizable UART transceiver: successor to the fixed-format bench UART model. Configurable bit period, data width, stop bits and FIFO depths, with valid/ready byte streams on both directions. Used both inside the SoC as the host-link UART and in the simulation harness as the host-side peer wired to the DUT's serial pins.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_txrx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state types and sizing helpers for the uart_txrx transceiver.
package uart_pkg;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_t;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxBreak
    } rx_state_t;

    // Bit-period counter width; wide enough for a two-stop-bit period.
    function automatic int unsigned cnt_width(input int unsigned cpb);
        return $clog2(cpb * 2);
    endfunction

    // Cycles from start-edge detection to the mid-start resample.
    function automatic int unsigned half_bit(input int unsigned cpb);
        return cpb / 2;
    endfunction

    function automatic int unsigned idx_width(input int unsigned bits);
        return $clog2(bits);
    endfunction

    // Parity over up to 9 data bits; callers zero-extend, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [8:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word fall-through FIFO; pushes into a full FIFO are dropped.
module uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge i_clock) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx: UART transceiver with TX/RX FIFOs and valid/ready byte streams.
// Define UART_TXRX_PARITY_EN to add a parity bit (even/odd per PARITY_ODD) to each frame.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned TX_FIFO_DEPTH  = 4,
    parameter int unsigned RX_FIFO_DEPTH  = 4,
    parameter int unsigned PARITY_ODD     = 0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_uart_rx,
    output logic                 o_uart_tx,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_overflow,
    output logic                 o_frame_error,
    output logic                 o_parity_error
);

    localparam int unsigned CW = cnt_width(CLOCKS_PER_BIT);
    localparam int unsigned IW = idx_width(DATA_BITS);
    localparam logic [CW-1:0] BitLast  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] StopLast = CW'(STOP_BITS * CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(half_bit(CLOCKS_PER_BIT) - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(DATA_BITS - 1);
    localparam logic          ParOdd   = (PARITY_ODD != 0);
`ifdef UART_TXRX_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    // ---------------- TX path ----------------
    logic [DATA_BITS-1:0] txf_rdata;
    logic                 txf_full, txf_empty, txf_pop;
    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [IW-1:0]        tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_line_q, tx_line_d;

    uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (i_tx_valid),
        .i_wdata (i_tx_data),
        .i_pop   (txf_pop),
        .o_rdata (txf_rdata),
        .o_full  (txf_full),
        .o_empty (txf_empty)
    );

    assign o_tx_ready = !txf_full;
    assign o_uart_tx  = tx_line_q;

    // TX framing: load from FIFO, then start/data/[parity]/stop; stop chains straight into the next start.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q == '0) ? '0 : tx_cnt_q - 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        txf_pop    = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_line_d = 1'b1;
                if (!txf_empty) begin
                    txf_pop    = 1'b1;
                    tx_shift_d = txf_rdata;
                    tx_par_d   = parity_of(9'(txf_rdata), ParOdd);
                    tx_cnt_d   = BitLast;
                    tx_line_d  = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxData;
                    tx_idx_d   = '0;
                    tx_cnt_d   = BitLast;
                    tx_line_d  = tx_shift_q[0];
                end
            end
            TxData: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BitLast;
                    if (tx_idx_q == IdxLast) begin
                        if (ParEn) begin
                            tx_state_d = TxParity;
                            tx_line_d  = tx_par_q;
                        end else begin
                            tx_state_d = TxStop;
                            tx_cnt_d   = StopLast;
                            tx_line_d  = 1'b1;
                        end
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end
            end
            TxParity: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxStop;
                    tx_cnt_d   = StopLast;
                    tx_line_d  = 1'b1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxIdle;
                    tx_line_d  = 1'b1;
                    if (!txf_empty) begin
                        txf_pop    = 1'b1;
                        tx_shift_d = txf_rdata;
                        tx_par_d   = parity_of(9'(txf_rdata), ParOdd);
                        tx_cnt_d   = BitLast;
                        tx_line_d  = 1'b0;
                        tx_state_d = TxStart;
                    end
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // TX state registers; the line flop resets high so an aborted frame idles at once.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // ---------------- RX path ----------------
    logic                 rx_sync1_q, rx_sync2_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [IW-1:0]        rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rxf_push, rxf_full, rxf_empty;
    logic                 frame_err, parity_err, overflow;

    uart_fifo #(.DEPTH(RX_FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (rxf_push),
        .i_wdata (rx_shift_q),
        .i_pop   (i_rx_ready),
        .o_rdata (o_rx_data),
        .o_full  (rxf_full),
        .o_empty (rxf_empty)
    );

    assign o_rx_valid    = !rxf_empty;
    assign o_rx_overflow = overflow;
    assign o_frame_error = frame_err;
`ifdef UART_TXRX_PARITY_EN
    assign o_parity_error = parity_err;
`else
    logic unused_parity_err;
    assign unused_parity_err = parity_err;
    assign o_parity_error    = 1'b0;
`endif

    // Two-flop synchroniser, idle-high after reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= i_uart_rx;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    // RX framing: mid-bit sampling; stop sample decides push or one error pulse (frame > parity > overflow).
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = (rx_cnt_q == '0) ? '0 : rx_cnt_q - 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rxf_push   = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
        overflow   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_sync2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = HalfLast;
                    rx_perr_d  = 1'b0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == '0) begin
                    if (!rx_sync2_q) begin
                        rx_state_d = RxData;
                        rx_cnt_d   = BitLast;
                        rx_idx_d   = '0;
                    end else begin
                        rx_state_d = RxIdle;
                    end
                end
            end
            RxData: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_cnt_d   = BitLast;
                    rx_idx_d   = rx_idx_q + 1'b1;
                    if (rx_idx_q == IdxLast) begin
                        rx_state_d = ParEn ? RxParity : RxStop;
                    end
                end
            end
            RxParity: begin
                if (rx_cnt_q == '0) begin
                    rx_perr_d  = (rx_sync2_q != parity_of(9'(rx_shift_q), ParOdd));
                    rx_cnt_d   = BitLast;
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == '0) begin
                    if (!rx_sync2_q) begin
                        frame_err  = 1'b1;
                        rx_state_d = RxBreak;
                    end else begin
                        rx_state_d = RxIdle;
                        if (rx_perr_q)     parity_err = 1'b1;
                        else if (rxf_full) overflow   = 1'b1;
                        else               rxf_push   = 1'b1;
                    end
                end
            end
            RxBreak: begin
                if (rx_sync2_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX state registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

endmodule
